dcache_data_array: RTL and testbench

// - N-way set-associative data array for the write-allocate, write-back data cache.
// - Generalises the direct-mapped data SRAM with:
//   - parametrised ways, sets and word width;
//   - per-word write mask;
//   - registered 1-cycle read with write-first bypass;
//   - hardware clear sequencer that zeroes the array after reset or on request.
// - Sits between the cache controller (tag/LRU/FSM) and the DRAM refill/writeback path.

---
 rtl/dcache_pkg.sv | 24 ++
 rtl/dcache_way_bank.sv | 48 ++++
 rtl/dcache_data_array.sv | 161 ++++++++++++++++
 tb/tb_dcache_data_array.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dcache_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : dcache_pkg
//  Description : Shared types and defaults for the data-cache data array:
//                default word/line geometry, word and line types, and the
//                clear/run state encoding of the array sequencer.
//  Revision    : 1.0  initial release
// ============================================================================
package dcache_pkg;

  // Default geometry, matching the DRAM word and block sizes.
  localparam int unsigned DEF_WORD_W      = 32;
  localparam int unsigned DEF_BLOCK_WORDS = 4;

  typedef logic [DEF_WORD_W-1:0]       word_t;
  typedef word_t [DEF_BLOCK_WORDS-1:0] line_t;

  typedef enum logic [0:0] {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } arr_state_e;

endpackage : dcache_pkg
`default_nettype wire

// File: rtl/dcache_way_bank.sv
`default_nettype none
// ============================================================================
//  Module      : dcache_way_bank
//  Description : One way of the data array: SETS lines of BLOCK_WORDS words,
//                masked synchronous write, combinational read.
//  Ports       : clk      - rising-edge clock
//                we       - write enable for this way
//                wr_index - set written
//                wr_mask  - per-word write enable
//                wr_data  - line written
//                rd_index - set read
//                rd_data  - stored line at rd_index (combinational)
//  Revision    : 1.0  initial release
// ============================================================================
module dcache_way_bank
  import dcache_pkg::*;
#(
  parameter  int unsigned WORD_W      = DEF_WORD_W,
  parameter  int unsigned BLOCK_WORDS = DEF_BLOCK_WORDS,
  parameter  int unsigned SETS        = 64,
  localparam int unsigned IDX_W       = $clog2(SETS)
) (
  input  logic                                clk,
  input  logic                                we,
  input  logic [IDX_W-1:0]                    wr_index,
  input  logic [BLOCK_WORDS-1:0]              wr_mask,
  input  logic [BLOCK_WORDS-1:0][WORD_W-1:0]  wr_data,
  input  logic [IDX_W-1:0]                    rd_index,
  output logic [BLOCK_WORDS-1:0][WORD_W-1:0]  rd_data
);

  // Storage is deliberately not reset; the top-level clear sequencer zeroes it.
  logic [BLOCK_WORDS-1:0][WORD_W-1:0] r_mem [SETS];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int b = 0; b < int'(BLOCK_WORDS); b++) begin
        if (wr_mask[b]) begin
          r_mem[wr_index][b] <= wr_data[b];
        end
      end
    end
  end

  assign rd_data = r_mem[rd_index];

endmodule : dcache_way_bank
`default_nettype wire

// File: rtl/dcache_data_array.sv
`default_nettype none
// ============================================================================
//  Module      : dcache_data_array
//  Description : N-way set-associative data array for the write-back data
//                cache. Masked per-word writes, registered one-cycle read of
//                all ways with write-first bypass, and a clear sequencer that
//                zeroes one set per cycle after reset or on clr_req.
//  Ports       : clk, rst_n           - clock, async active-low reset
//                clr_req / busy        - clear request / clear in progress
//                rd_en, rd_index       - read request and set
//                rd_valid, rd_data     - registered read result (all ways)
//                wr_en, wr_index,
//                wr_way, wr_mask,
//                wr_data               - masked line write to one way
//  Revision    : 1.0  initial release
// ============================================================================
module dcache_data_array
  import dcache_pkg::*;
#(
  parameter  int unsigned WORD_W      = DEF_WORD_W,
  parameter  int unsigned BLOCK_WORDS = DEF_BLOCK_WORDS,
  parameter  int unsigned SETS        = 64,
  parameter  int unsigned WAYS        = 2,
  localparam int unsigned IDX_W       = $clog2(SETS),
  localparam int unsigned WAY_W       = (WAYS > 1) ? $clog2(WAYS) : 1
) (
  input  logic                                        clk,
  input  logic                                        rst_n,
  input  logic                                        clr_req,
  output logic                                        busy,
  input  logic                                        rd_en,
  input  logic [IDX_W-1:0]                            rd_index,
  output logic                                        rd_valid,
  output logic [WAYS-1:0][BLOCK_WORDS-1:0][WORD_W-1:0] rd_data,
  input  logic                                        wr_en,
  input  logic [IDX_W-1:0]                            wr_index,
  input  logic [WAY_W-1:0]                            wr_way,
  input  logic [BLOCK_WORDS-1:0]                      wr_mask,
  input  logic [BLOCK_WORDS-1:0][WORD_W-1:0]          wr_data
);

  arr_state_e       r_state, w_state_nxt;
  logic [IDX_W-1:0] r_cnt, w_cnt_nxt;
  logic             w_clearing;
  logic             w_run;

  assign w_clearing = (r_state == CLEAR);
  assign w_run      = (r_state == RUN);
  assign busy       = w_clearing;

  // --------------------------------------------------------------------------
  // Clear sequencer
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= CLEAR;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      CLEAR: begin
        // clr_req is not looked at here, so a request mid-clear cannot restart it.
        w_cnt_nxt = r_cnt + 1'b1;
        if (r_cnt == IDX_W'(SETS - 1)) begin
          w_state_nxt = RUN;
          w_cnt_nxt   = '0;
        end
      end
      RUN: begin
        if (clr_req) begin
          w_state_nxt = CLEAR;
          w_cnt_nxt   = '0;
        end
      end
      default: begin
        w_state_nxt = CLEAR;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Way banks: during a clear every way is written with zeros at r_cnt
  // --------------------------------------------------------------------------
  logic [IDX_W-1:0]                           w_bank_idx;
  logic [BLOCK_WORDS-1:0]                     w_bank_mask;
  logic [BLOCK_WORDS-1:0][WORD_W-1:0]         w_bank_data;
  logic [WAYS-1:0]                            w_way_we;
  logic [WAYS-1:0][BLOCK_WORDS-1:0][WORD_W-1:0] w_rd_raw;
  logic [WAYS-1:0][BLOCK_WORDS-1:0][WORD_W-1:0] w_rd_merged;

  assign w_bank_idx  = w_clearing ? r_cnt : wr_index;
  assign w_bank_mask = w_clearing ? '1    : wr_mask;
  assign w_bank_data = w_clearing ? '0    : wr_data;

  genvar g;
  generate
    for (g = 0; g < int'(WAYS); g++) begin : g_way
      // An out-of-range wr_way matches no bank and is dropped.
      assign w_way_we[g] = w_clearing | (w_run & wr_en & (wr_way == WAY_W'(g)));

      dcache_way_bank #(
        .WORD_W      (WORD_W),
        .BLOCK_WORDS (BLOCK_WORDS),
        .SETS        (SETS)
      ) u_bank (
        .clk      (clk),
        .we       (w_way_we[g]),
        .wr_index (w_bank_idx),
        .wr_mask  (w_bank_mask),
        .wr_data  (w_bank_data),
        .rd_index (rd_index),
        .rd_data  (w_rd_raw[g])
      );
    end
  endgenerate

  // Write-first bypass: a same-set write shows up in this cycle's read.
  always_comb begin
    w_rd_merged = w_rd_raw;
    for (int w = 0; w < int'(WAYS); w++) begin
      if (w_run && w_way_we[w] && (wr_index == rd_index)) begin
        for (int b = 0; b < int'(BLOCK_WORDS); b++) begin
          if (wr_mask[b]) begin
            w_rd_merged[w][b] = wr_data[b];
          end
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Read output register
  // --------------------------------------------------------------------------
  logic                                         r_rd_valid;
  logic [WAYS-1:0][BLOCK_WORDS-1:0][WORD_W-1:0] r_rd_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_valid <= 1'b0;
      r_rd_data  <= '0;
    end else begin
      r_rd_valid <= w_run & rd_en;
      if (w_run && rd_en) begin
        r_rd_data <= w_rd_merged;
      end
    end
  end

  assign rd_valid = r_rd_valid;
  assign rd_data  = r_rd_data;

endmodule : dcache_data_array
`default_nettype wire

// File: tb/tb_dcache_data_array.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_dcache_data_array
//  Description : Self-checking bench for dcache_data_array with a reference
//                memory model and a read scoreboard queue.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_dcache_data_array;
  import dcache_pkg::*;

  localparam int WW = 32;
  localparam int BW = 4;
  localparam int NS = 64;
  localparam int NW = 2;
  localparam int IW = 6;
  localparam int AW = 1;

  typedef logic [NW-1:0][BW-1:0][WW-1:0] tset_t;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               clr_req;
  logic               busy;
  logic               rd_en;
  logic [IW-1:0]      rd_index;
  logic               rd_valid;
  tset_t              rd_data;
  logic               wr_en;
  logic [IW-1:0]      wr_index;
  logic [AW-1:0]      wr_way;
  logic [BW-1:0]      wr_mask;
  line_t              wr_data;

  dcache_data_array #(
    .WORD_W (WW), .BLOCK_WORDS (BW), .SETS (NS), .WAYS (NW)
  ) dut (
    .clk (clk), .rst_n (rst_n), .clr_req (clr_req), .busy (busy),
    .rd_en (rd_en), .rd_index (rd_index), .rd_valid (rd_valid), .rd_data (rd_data),
    .wr_en (wr_en), .wr_index (wr_index), .wr_way (wr_way),
    .wr_mask (wr_mask), .wr_data (wr_data)
  );

  always #5 clk = ~clk;

  // Reference model state
  line_t  mdl [NW][NS];
  int     clear_left;
  logic   exp_valid;
  tset_t  exp_rd;
  tset_t  sb_q [$];
  int     n_checks = 0;
  int     n_err    = 0;

  task automatic set_idle();
    clr_req = 0; rd_en = 0; wr_en = 0;
    rd_index = '0; wr_index = '0; wr_way = '0; wr_mask = '0; wr_data = '0;
  endtask

  // Advance one clock edge and update the model from the inputs seen there.
  task automatic tick();
    tset_t e;
    @(posedge clk);
    if (!rst_n) begin
      clear_left = NS;
      exp_valid  = 1'b0;
    end else if (clear_left > 0) begin
      for (int w = 0; w < NW; w++) mdl[w][NS - clear_left] = '0;
      clear_left--;
      exp_valid = 1'b0;
    end else begin
      if (wr_en)
        for (int b = 0; b < BW; b++)
          if (wr_mask[b]) mdl[wr_way][wr_index][b] = wr_data[b];
      exp_valid = rd_en;
      if (rd_en) begin
        for (int w = 0; w < NW; w++) e[w] = mdl[w][rd_index];
        sb_q.push_back(e);
      end
      if (clr_req) clear_left = NS;
    end
    #1;
  endtask

  task automatic assert_reset();
    rst_n = 0;
    set_idle();
    #1;
    clear_left = NS;
    exp_valid  = 1'b0;
    exp_rd     = '0;
    sb_q.delete();
  endtask

  task automatic test_reset();
    int busy_cnt;
    assert_reset();
    n_checks++;
    if (busy !== 1'b1) begin n_err++; $display("FAIL reset_busy: got %0b want 1", busy); end
    n_checks++;
    if (rd_valid !== 1'b0) begin n_err++; $display("FAIL reset_rd_valid: got %0b want 0", rd_valid); end
    n_checks++;
    if (rd_data !== '0) begin n_err++; $display("FAIL reset_rd_data: got %h want 0", rd_data); end
    tick(); tick();
    rst_n = 1;
    busy_cnt = 0;
    for (int i = 0; i < 200 && busy === 1'b1; i++) begin
      busy_cnt++;
      tick();
    end
    n_checks++;
    if (busy_cnt != 64) begin n_err++; $display("FAIL reset_busy_len: got %0d cycles want 64", busy_cnt); end
    foreach (mdl[w, s]) begin end
    for (int k = 0; k < 3; k++) begin
      rd_en = 1; rd_index = IW'((k == 0) ? 0 : (k == 1) ? 63 : 17);
      tick();
      rd_en = 0;
      n_checks++;
      if (rd_valid !== 1'b1) begin n_err++; $display("FAIL reset_read_valid: got %0b want 1", rd_valid); end
      if (sb_q.size() > 0) exp_rd = sb_q.pop_front();
      n_checks++;
      if (rd_data !== '0) begin n_err++; $display("FAIL reset_read_zero idx %0d: got %h want 0", rd_index, rd_data); end
    end
  endtask

  task automatic test_write_read();
    line_t abcd;
    abcd = {32'hAAAA_0001, 32'hBBBB_0002, 32'hCCCC_0003, 32'hDDDD_0004};
    wr_en = 1; wr_index = 5; wr_way = 1; wr_mask = 4'b1111; wr_data = abcd;
    tick();
    set_idle();
    rd_en = 1; rd_index = 5;
    tick();
    rd_en = 0;
    n_checks++;
    if (rd_valid !== 1'b1) begin n_err++; $display("FAIL wr_rd_valid: got %0b want 1", rd_valid); end
    if (sb_q.size() > 0) exp_rd = sb_q.pop_front();
    n_checks++;
    if (rd_data[1] !== abcd) begin n_err++; $display("FAIL wr_rd_way1: got %h want %h", rd_data[1], abcd); end
    n_checks++;
    if (rd_data[0] !== '0) begin n_err++; $display("FAIL wr_rd_way0: got %h want 0", rd_data[0]); end
    tick();
    n_checks++;
    if (rd_valid !== 1'b0) begin n_err++; $display("FAIL wr_rd_valid_drop: got %0b want 0", rd_valid); end
    n_checks++;
    if (rd_data[1] !== abcd) begin n_err++; $display("FAIL wr_rd_hold: got %h want %h", rd_data[1], abcd); end
  endtask

  task automatic test_bypass();
    line_t nines, exp_merge;
    nines     = {32'd9, 32'd9, 32'd9, 32'd9};
    exp_merge = {32'd9, 32'd2, 32'd9, 32'd4};
    wr_en = 1; wr_index = 7; wr_way = 0; wr_mask = 4'b1111; wr_data = nines;
    tick();
    wr_mask = 4'b0101; wr_data = {32'd1, 32'd2, 32'd3, 32'd4};
    rd_en = 1; rd_index = 7;
    tick();
    set_idle();
    n_checks++;
    if (rd_valid !== 1'b1) begin n_err++; $display("FAIL bypass_valid: got %0b want 1", rd_valid); end
    if (sb_q.size() > 0) exp_rd = sb_q.pop_front();
    n_checks++;
    if (rd_data[0] !== exp_merge) begin n_err++; $display("FAIL bypass_merge: got %h want %h", rd_data[0], exp_merge); end
    n_checks++;
    if (rd_data !== exp_rd) begin n_err++; $display("FAIL bypass_model: got %h want %h", rd_data, exp_rd); end
    // Mask 0 is a no-op even with a same-set read.
    wr_en = 1; wr_index = 7; wr_way = 0; wr_mask = '0; wr_data = '1;
    rd_en = 1; rd_index = 7;
    tick();
    set_idle();
    if (sb_q.size() > 0) exp_rd = sb_q.pop_front();
    n_checks++;
    if (rd_data[0] !== exp_merge) begin n_err++; $display("FAIL bypass_mask0: got %h want %h", rd_data[0], exp_merge); end
    // Different-index read and write proceed independently.
    wr_en = 1; wr_index = 8; wr_way = 1; wr_mask = 4'b1111; wr_data = {4{32'h1234_5678}};
    rd_en = 1; rd_index = 7;
    tick();
    set_idle();
    if (sb_q.size() > 0) exp_rd = sb_q.pop_front();
    n_checks++;
    if (rd_data !== {128'd0, exp_merge}) begin n_err++; $display("FAIL bypass_diff_idx: got %h want %h", rd_data, {128'd0, exp_merge}); end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 300; i++) begin
      rd_en    = 1'($urandom_range(0, 1));
      rd_index = IW'($urandom_range(0, 7));
      wr_en    = 1'($urandom_range(0, 1));
      wr_index = IW'($urandom_range(0, 7));
      wr_way   = AW'($urandom_range(0, 1));
      wr_mask  = BW'($urandom_range(0, 15));
      for (int b = 0; b < BW; b++) wr_data[b] = $urandom;
      tick();
      n_checks++;
      if (rd_valid !== exp_valid) begin n_err++; $display("FAIL b2b_valid cyc %0d: got %0b want %0b", i, rd_valid, exp_valid); end
      if (exp_valid && sb_q.size() > 0) exp_rd = sb_q.pop_front();
      n_checks++;
      if (rd_data !== exp_rd) begin n_err++; $display("FAIL b2b_data cyc %0d: got %h want %h", i, rd_data, exp_rd); end
    end
    set_idle();
  endtask

  task automatic test_clear_req();
    int busy_cnt;
    wr_en = 1; wr_index = 3; wr_way = 0; wr_mask = '1; wr_data = {4{32'hDEAD_BEEF}};
    tick();
    set_idle();
    clr_req = 1;
    tick();
    clr_req = 0;
    busy_cnt = 0;
    for (int i = 0; i < 200; i++) begin
      if (busy !== 1'b1) break;
      busy_cnt++;
      n_checks++;
      if (rd_valid !== 1'b0) begin n_err++; $display("FAIL clr_rd_valid cyc %0d: got %0b want 0", busy_cnt, rd_valid); end
      rd_en = 1; rd_index = 3;
      wr_en = 1; wr_index = IW'(busy_cnt[0] ? 3 : 5); wr_way = 1; wr_mask = '1;
      wr_data = {4{$urandom}};
      clr_req = (busy_cnt == 11);
      tick();
      set_idle();
    end
    n_checks++;
    if (busy_cnt != 64) begin n_err++; $display("FAIL clr_busy_len: got %0d cycles want 64", busy_cnt); end
    n_checks++;
    if (rd_valid !== 1'b0) begin n_err++; $display("FAIL clr_valid_after: got %0b want 0", rd_valid); end
    for (int k = 0; k < 2; k++) begin
      rd_en = 1; rd_index = IW'(k == 0 ? 3 : 5);
      tick();
      set_idle();
      if (sb_q.size() > 0) exp_rd = sb_q.pop_front();
      n_checks++;
      if (rd_data !== '0) begin n_err++; $display("FAIL clr_read_zero idx %0d: got %h want 0", (k == 0 ? 3 : 5), rd_data); end
    end
  endtask

  task automatic test_reset_mid_clear();
    int busy_cnt;
    // In-flight read dropped by reset.
    wr_en = 1; wr_index = 9; wr_way = 1; wr_mask = '1; wr_data = {4{32'h0F0F_0F0F}};
    tick();
    set_idle();
    rd_en = 1; rd_index = 9;
    tick();
    set_idle();
    n_checks++;
    if (rd_valid !== 1'b1) begin n_err++; $display("FAIL inflight_valid: got %0b want 1", rd_valid); end
    assert_reset();
    n_checks++;
    if (rd_valid !== 1'b0 || rd_data !== '0) begin n_err++; $display("FAIL inflight_drop: got valid %0b data %h want 0/0", rd_valid, rd_data); end
    tick();
    rst_n = 1;
    tick(); tick();
    while (busy === 1'b1 && clear_left > 0) tick();
    // Clear request, then reset at clear count 30.
    clr_req = 1;
    tick();
    clr_req = 0;
    for (int i = 0; i < 30; i++) tick();
    assert_reset();
    n_checks++;
    if (busy !== 1'b1) begin n_err++; $display("FAIL midclr_busy: got %0b want 1", busy); end
    tick();
    rst_n = 1;
    busy_cnt = 0;
    for (int i = 0; i < 200 && busy === 1'b1; i++) begin
      busy_cnt++;
      tick();
    end
    n_checks++;
    if (busy_cnt != 64) begin n_err++; $display("FAIL midclr_busy_len: got %0d cycles want 64", busy_cnt); end
    rd_en = 1; rd_index = 9;
    tick();
    set_idle();
    if (sb_q.size() > 0) exp_rd = sb_q.pop_front();
    n_checks++;
    if (rd_data !== '0) begin n_err++; $display("FAIL midclr_read_zero: got %h want 0", rd_data); end
  endtask

  initial begin
    rst_n = 0;
    set_idle();
    #2;
    test_reset();
    test_write_read();
    test_bypass();
    test_back_to_back();
    test_clear_req();
    test_reset_mid_clear();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end

endmodule : tb_dcache_data_array
`default_nettype wire
